// File: rtl/uart_tx.sv
// Byte-serial UART transmitter: valid/ready push into a small FIFO, 8N1 framing on Tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx #(
  parameter int unsigned SYS_CLK_FREQ   = 100000000,
  parameter int unsigned UART_BAUD_RATE = 115200,
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned FIFO_DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BYTE_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 Tx,
  output logic                 tx_busy
);

  localparam int unsigned CLKS_PER_BIT = SYS_CLK_FREQ / UART_BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W        = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
  localparam int unsigned AW           = FIFO_DEPTH_LOG;
  localparam int unsigned PTR_W        = FIFO_DEPTH_LOG + 1;
  localparam int unsigned DEPTH        = 1 << FIFO_DEPTH_LOG;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [BYTE_SIZE-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [BYTE_SIZE-1:0] mem_q [DEPTH];
  logic [BYTE_SIZE-1:0] head_c;
  logic                 full_c, empty_c;
  logic                 push_c, pop_c;
  logic                 bit_done_c;

  // FIFO status derives only from registered pointers, so tx_ready never depends on tx_valid.
  assign full_c   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c  = (wr_ptr_q == rd_ptr_q);
  assign push_c   = tx_valid && !full_c;
  assign head_c   = mem_q[rd_ptr_q[AW-1:0]];

  assign tx_ready = !full_c;
  assign Tx       = tx_q;
  assign tx_busy  = (state_q != ST_IDLE) || !empty_c;

  assign bit_done_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Storage array carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Frame sequencer: Tx is the registered copy of tx_d, so the line never glitches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty_c) begin
          pop_c    = 1'b1;
          shift_d  = head_c;
          state_d  = ST_START;
          cnt_d    = '0;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head_c;
`endif
        end
      end

      ST_START: begin
        if (bit_done_c) begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_done_c) begin
          cnt_d = '0;
          if (bit_idx_q == BIT_W'(BYTE_SIZE - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done_c) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_done_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clocks per bit with a 4-entry FIFO.
// A frame monitor decodes Tx and checks bytes against a scoreboard queue.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = CPB * (10 + PAR);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       Tx;
  logic       tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  typedef struct {
    int   k;
    logic tx;
    logic busy;
  } vec_t;

  uart_tx #(
    .SYS_CLK_FREQ  (16),
    .UART_BAUD_RATE(1),
    .BYTE_SIZE     (8),
    .FIFO_DEPTH_LOG(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .Tx      (Tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  task automatic push(input logic [7:0] b, input bit track);
    int t;
    t = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      fail_now("push_timeout");
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) sb.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (tx_busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(nm, int'(tx_busy), 0);
  endtask

  task automatic wait_n(input int n, output logic ab);
    ab = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (!rst) ab = 1'b1;
    end
  endtask

  // Samples each bit at its midpoint; a reset seen anywhere abandons the frame.
  task automatic recv_frame(output logic ab, output logic st, output logic [7:0] d,
                            output logic p, output logic sp);
    d  = '0;
    p  = 1'b0;
    st = 1'b1;
    sp = 1'b0;
    wait_n(7, ab);
    if (ab) return;
    st = Tx;
    for (int i = 0; i < 8; i++) begin
      wait_n(CPB, ab);
      if (ab) return;
      d[i] = Tx;
    end
`ifdef UART_TX_PARITY_EN
    wait_n(CPB, ab);
    if (ab) return;
    p = Tx;
`endif
    wait_n(CPB, ab);
    if (ab) return;
    sp = Tx;
  endtask

  initial begin : monitor
    logic       ab, st, p, sp;
    logic [7:0] d, e;
    forever begin
      @(negedge clk);
      if (rst && Tx == 1'b0) begin
        recv_frame(ab, st, d, p, sp);
        if (!ab) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_frame");
          end else begin
            e = sb.pop_front();
            check("frame_start_bit", int'(st), 0);
            check("frame_data", int'(d), int'(e));
            check("frame_stop_bit", int'(sp), 1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", int'(p), int'(^e));
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[$];
    int   k, toggles, busy_hi, ready_lo, low_cnt;
    logic prev;

    // Single 0xA5 frame: {cycle after accept, Tx, tx_busy}; bits LSB first 1,0,1,0,0,1,0,1.
    vecs.push_back('{0,   1'b1, 1'b1});
    vecs.push_back('{1,   1'b0, 1'b1});
    vecs.push_back('{16,  1'b0, 1'b1});
    vecs.push_back('{17,  1'b1, 1'b1});
    vecs.push_back('{32,  1'b1, 1'b1});
    vecs.push_back('{33,  1'b0, 1'b1});
    vecs.push_back('{49,  1'b1, 1'b1});
    vecs.push_back('{65,  1'b0, 1'b1});
    vecs.push_back('{81,  1'b0, 1'b1});
    vecs.push_back('{97,  1'b1, 1'b1});
    vecs.push_back('{113, 1'b0, 1'b1});
    vecs.push_back('{129, 1'b1, 1'b1});
    vecs.push_back('{144, 1'b1, 1'b1});
    vecs.push_back('{145, (PAR == 1) ? 1'b0 : 1'b1, 1'b1});
    vecs.push_back('{FL,  1'b1, 1'b1});
    vecs.push_back('{FL + 1, 1'b1, 1'b0});
    vecs.push_back('{FL + 40, 1'b1, 1'b0});

    // Reset: asynchronous effect before any clock edge, then stable through release.
    #1 rst = 1'b0;
    #1;
    check("reset_tx_async", int'(Tx), 1);
    check("reset_busy_async", int'(tx_busy), 0);
    check("reset_ready_async", int'(tx_ready), 1);
    repeat (5) begin
      @(negedge clk);
      check("reset_hold_tx", int'(Tx), 1);
      check("reset_hold_busy", int'(tx_busy), 0);
      check("reset_hold_ready", int'(tx_ready), 1);
    end
    rst = 1'b1;
    toggles = 0; busy_hi = 0; ready_lo = 0;
    prev = Tx;
    repeat (100) begin
      @(negedge clk);
      if (Tx !== prev) toggles++;
      prev = Tx;
      if (tx_busy) busy_hi++;
      if (!tx_ready) ready_lo++;
    end
    check("post_reset_tx_edges", toggles, 0);
    check("post_reset_busy_cycles", busy_hi, 0);
    check("post_reset_notready_cycles", ready_lo, 0);

    // Single byte, checked cycle by cycle against the table.
    push(8'hA5, 1'b1);
    k = 0;
    foreach (vecs[i]) begin
      while (k < vecs[i].k) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("a5_tx_k%0d", vecs[i].k), int'(Tx), int'(vecs[i].tx));
      check($sformatf("a5_busy_k%0d", vecs[i].k), int'(tx_busy), int'(vecs[i].busy));
    end
    wait_idle("a5_idle");

    // Back-to-back: one idle-high cycle between frames.
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    k = 1;
    repeat (143) @(negedge clk);
    check("b2b_first_bit7", int'(Tx), 0);
    repeat (FL - 144) @(negedge clk);
    check("b2b_stop_end", int'(Tx), 1);
    @(negedge clk);
    check("b2b_idle_gap", int'(Tx), 1);
    check("b2b_busy_gap", int'(tx_busy), 1);
    @(negedge clk);
    check("b2b_second_start", int'(Tx), 0);
    repeat (CPB + 8) @(negedge clk);
    check("b2b_second_bit0", int'(Tx), 1);
    wait_idle("b2b_idle");

    // Full FIFO: tx_valid effectively held; the sixth byte stalls until space frees.
    for (int i = 1; i <= 6; i++) begin
      push(8'(i), 1'b1);
      if (i == 5) check("fifo_full_ready", int'(tx_ready), 0);
      if (i == 6) check("fifo_refill_busy", int'(tx_busy), 1);
    end
    wait_idle("fifo_idle");
    check("fifo_all_delivered", sb.size(), 0);

    // Reset during data bit 3 of 0x3C, with 0x81 queued behind it.
    push(8'h3C, 1'b0);
    push(8'h81, 1'b0);
    repeat (69) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_tx", int'(Tx), 1);
    check("midreset_busy", int'(tx_busy), 0);
    check("midreset_ready", int'(tx_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    low_cnt = 0; busy_hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (!Tx) low_cnt++;
      if (tx_busy) busy_hi++;
    end
    check("midreset_no_tx_activity", low_cnt, 0);
    check("midreset_fifo_discarded", busy_hi, 0);
    push(8'h55, 1'b1);
    wait_idle("post_midreset_idle");

`ifdef UART_TX_PARITY_EN
    // Parity bit occupies cycles 145..160 after acceptance.
    push(8'h07, 1'b1);
    repeat (151) @(negedge clk);
    check("parity_07", int'(Tx), 1);
    repeat (24) @(negedge clk);
    check("parity_07_stop", int'(Tx), 1);
    wait_idle("parity_07_idle");
    push(8'h03, 1'b1);
    repeat (151) @(negedge clk);
    check("parity_03", int'(Tx), 0);
    wait_idle("parity_03_idle");
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
